// File: rtl/pll_pkg.sv
// Shared PLL definitions: lock-detector state encoding, PLL-wide default
// constants and the sampled-clock rising-edge helper.
package pll_pkg;

    typedef enum logic [1:0] {
        WAIT_FIRST,
        ACQUIRING,
        LOCKED,
        SLIPPING
    } lock_state_t;

    localparam int PLL_DIV_RATIO = 16;

    function automatic logic rise_detect(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/pll_window_counter.sv
// Edge detection on the sampled reference/output clocks and per-window edge
// counting; flags window open/close and presents the closing edge count.
module pll_window_counter
    import pll_pkg::*;
#(
    parameter int WINDOW_REF_CYCLES = 4,
    parameter int COUNT_W           = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               reference_clk_digital,
    input  logic               output_clk_digital,
    input  logic               window_active,
    output logic               window_open,
    output logic               window_close,
    output logic [COUNT_W-1:0] close_count
);

    localparam int REF_W = $clog2(WINDOW_REF_CYCLES + 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(WINDOW_REF_CYCLES - 1);

    logic               ref_p0;
    logic               out_p0;
    logic               ref_rise;
    logic               out_rise;
    logic [REF_W-1:0]   ref_cnt;
    logic [COUNT_W-1:0] out_cnt;
    logic [COUNT_W-1:0] out_next;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // An output edge on the closing reference edge belongs to the closing window.
    always_comb begin
        ref_rise     = rise_detect(reference_clk_digital, ref_p0);
        out_rise     = rise_detect(output_clk_digital, out_p0);
        window_open  = ~window_active & ref_rise;
        window_close = window_active & ref_rise & (ref_cnt == REF_LAST);
        out_next     = out_rise ? sat_inc(out_cnt) : out_cnt;
        close_count  = out_next;
    end

    // Stage p0: registered samples and edge counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_p0  <= 1'b0;
            out_p0  <= 1'b0;
            ref_cnt <= '0;
            out_cnt <= '0;
        end else begin
            ref_p0 <= reference_clk_digital;
            out_p0 <= output_clk_digital;
            if (window_open || window_close) begin
                ref_cnt <= '0;
                out_cnt <= '0;
            end else if (window_active) begin
                if (ref_rise) begin
                    ref_cnt <= ref_cnt + 1'b1;
                end
                out_cnt <= out_next;
            end
        end
    end

endmodule

// File: rtl/pll_lock_detector.sv
// PLL frequency-lock observer: compares output edges per reference window to
// the divide ratio and debounces the result into a lock flag.
module pll_lock_detector
    import pll_pkg::*;
#(
    parameter int DIV_RATIO         = PLL_DIV_RATIO,
    parameter int WINDOW_REF_CYCLES = 4,
    parameter int TOL               = 2,
    parameter int LOCK_WINDOWS      = 3,
    parameter int UNLOCK_WINDOWS    = 2,
    parameter int COUNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reference_clk_digital,
    input  logic             output_clk_digital,
    output logic             lock_digital,
    output logic             lost_lock_digital,
    output logic             window_done_digital,
    output logic [COUNT_W:0] freq_error_real
);

    localparam logic signed [COUNT_W:0] EXPECTED = (COUNT_W + 1)'(DIV_RATIO * WINDOW_REF_CYCLES);
    localparam logic signed [COUNT_W:0] TOL_S    = (COUNT_W + 1)'(TOL);
    localparam logic [7:0] LOCK_N   = 8'(LOCK_WINDOWS);
    localparam logic [7:0] UNLOCK_N = 8'(UNLOCK_WINDOWS);

    lock_state_t        state;
    lock_state_t        state_next;
    logic [7:0]         good_cnt;
    logic [7:0]         good_next;
    logic [7:0]         bad_cnt;
    logic [7:0]         bad_next;
    logic               lost_next;
    logic               window_active;
    logic               window_open;
    logic               window_close;
    logic [COUNT_W-1:0] close_count;
    logic signed [COUNT_W:0] err;
    logic               good_window;

    function automatic logic signed [COUNT_W:0] freq_err(input logic [COUNT_W-1:0] count);
        return $signed({1'b0, count}) - EXPECTED;
    endfunction

    function automatic logic within_tol(input logic signed [COUNT_W:0] e);
        return (e >= -TOL_S) && (e <= TOL_S);
    endfunction

    pll_window_counter #(
        .WINDOW_REF_CYCLES(WINDOW_REF_CYCLES),
        .COUNT_W          (COUNT_W)
    ) u_window_counter (
        .clk                  (clk),
        .reset                (reset),
        .reference_clk_digital(reference_clk_digital),
        .output_clk_digital   (output_clk_digital),
        .window_active        (window_active),
        .window_open          (window_open),
        .window_close         (window_close),
        .close_count          (close_count)
    );

    assign window_active = (state != WAIT_FIRST);
    assign err           = freq_err(close_count);
    assign good_window   = within_tol(err);

    // Stage p1: state, debounce counters and registered window results
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= WAIT_FIRST;
            good_cnt            <= '0;
            bad_cnt             <= '0;
            lost_lock_digital   <= 1'b0;
            window_done_digital <= 1'b0;
            freq_error_real     <= '0;
        end else begin
            state               <= state_next;
            good_cnt            <= good_next;
            bad_cnt             <= bad_next;
            lost_lock_digital   <= lost_next;
            window_done_digital <= window_close;
            if (window_close) begin
                freq_error_real <= err;
            end
        end
    end

    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        bad_next   = bad_cnt;
        lost_next  = 1'b0;
        case (state)
            WAIT_FIRST: begin
                good_next = '0;
                bad_next  = '0;
                if (window_open) begin
                    state_next = ACQUIRING;
                end
            end
            ACQUIRING: begin
                if (window_close) begin
                    if (!good_window) begin
                        good_next = '0;
                    end else if (good_cnt + 8'd1 >= LOCK_N) begin
                        state_next = LOCKED;
                        good_next  = '0;
                    end else begin
                        good_next = good_cnt + 8'd1;
                    end
                end
            end
            LOCKED: begin
                if (window_close && !good_window) begin
                    if (UNLOCK_N <= 8'd1) begin
                        state_next = ACQUIRING;
                        lost_next  = 1'b1;
                        good_next  = '0;
                        bad_next   = '0;
                    end else begin
                        state_next = SLIPPING;
                        bad_next   = 8'd1;
                    end
                end
            end
            SLIPPING: begin
                if (window_close) begin
                    if (good_window) begin
                        state_next = LOCKED;
                        bad_next   = '0;
                    end else if (bad_cnt + 8'd1 >= UNLOCK_N) begin
                        state_next = ACQUIRING;
                        lost_next  = 1'b1;
                        good_next  = '0;
                        bad_next   = '0;
                    end else begin
                        bad_next = bad_cnt + 8'd1;
                    end
                end
            end
            default: state_next = WAIT_FIRST;
        endcase
    end

    // Lock is held through SLIPPING so a single bad window does not drop it.
    always_comb begin
        lock_digital = (state == LOCKED) || (state == SLIPPING);
    end

endmodule

// File: tb/tb_pll_lock_detector.sv
// Directed bench for pll_lock_detector: reference period = 40 clk, output
// edges placed inside each period to give an exact per-window edge count.
module tb_pll_lock_detector;

    localparam int COUNT_W = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic reference_clk_digital = 1'b0;
    logic output_clk_digital = 1'b0;
    logic lock_digital;
    logic lost_lock_digital;
    logic window_done_digital;
    logic [COUNT_W:0] freq_error_real;

    int n_checks = 0;
    int n_pass = 0;
    int lost_cnt = 0;
    logic [COUNT_W:0] err_q[$];
    logic lock_q[$];
    logic lost_q[$];
    int cyc_q[$];

    always #5 clk = ~clk;

    pll_lock_detector #(
        .DIV_RATIO(16), .WINDOW_REF_CYCLES(4), .TOL(2),
        .LOCK_WINDOWS(3), .UNLOCK_WINDOWS(2), .COUNT_W(COUNT_W)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .reference_clk_digital(reference_clk_digital),
        .output_clk_digital   (output_clk_digital),
        .lock_digital         (lock_digital),
        .lost_lock_digital    (lost_lock_digital),
        .window_done_digital  (window_done_digital),
        .freq_error_real      (freq_error_real)
    );

    task automatic drive_cycle(input logic r, input logic o, input int c);
        reference_clk_digital = r;
        output_clk_digital = o;
        @(posedge clk);
        #1;
        if (window_done_digital === 1'b1) begin
            err_q.push_back(freq_error_real);
            lock_q.push_back(lock_digital);
            lost_q.push_back(lost_lock_digital);
            cyc_q.push_back(c);
        end
        if (lost_lock_digital === 1'b1) lost_cnt++;
    endtask

    // One reference period; coinc puts an extra output edge on the reference edge.
    task automatic ref_period(input int n, input bit coinc);
        logic o;
        for (int c = 0; c < 40; c++) begin
            if (coinc) o = (c == 0) || (c >= 3 && c % 2 == 1 && (c - 3) / 2 < n);
            else       o = (c % 2 == 1) && ((c - 1) / 2 < n);
            drive_cycle(c < 20, o, c);
        end
    endtask

    task automatic run_window(input int total);
        for (int p = 0; p < 4; p++)
            ref_period(total / 4 + ((p < total % 4) ? 1 : 0), 1'b0);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        reference_clk_digital = 1'b0;
        output_clk_digital = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        err_q.delete(); lock_q.delete(); lost_q.delete(); cyc_q.delete();
        lost_cnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (lock_digital !== 1'b0) $display("FAIL reset_lock: got %b expected 0", lock_digital); else n_pass++;
        n_checks++; if (lost_lock_digital !== 1'b0) $display("FAIL reset_lost: got %b expected 0", lost_lock_digital); else n_pass++;
        n_checks++; if (window_done_digital !== 1'b0) $display("FAIL reset_done: got %b expected 0", window_done_digital); else n_pass++;
        n_checks++; if (freq_error_real !== '0) $display("FAIL reset_err: got %0d expected 0", $signed(freq_error_real)); else n_pass++;
    endtask

    task automatic test_exact();
        logic exp_lock[5] = '{0, 0, 1, 1, 1};
        apply_reset();
        repeat (5) run_window(64);
        ref_period(0, 1'b0);
        n_checks++; if (err_q.size() != 5) $display("FAIL exact_windows: got %0d expected 5", err_q.size()); else n_pass++;
        for (int i = 0; i < 5 && i < err_q.size(); i++) begin
            n_checks++; if (err_q[i] !== 17'(0)) $display("FAIL exact_err[%0d]: got %0d expected 0", i, $signed(err_q[i])); else n_pass++;
            n_checks++; if (lock_q[i] !== exp_lock[i]) $display("FAIL exact_lock[%0d]: got %b expected %b", i, lock_q[i], exp_lock[i]); else n_pass++;
            n_checks++; if (cyc_q[i] != 0) $display("FAIL exact_latency[%0d]: got cycle %0d expected 0", i, cyc_q[i]); else n_pass++;
        end
        n_checks++; if (lost_cnt != 0) $display("FAIL exact_lost: got %0d expected 0", lost_cnt); else n_pass++;
    endtask

    task automatic test_tolerance();
        logic exp_lock[3] = '{0, 0, 1};
        apply_reset();
        repeat (3) run_window(66);
        ref_period(0, 1'b0);
        n_checks++; if (err_q.size() != 3) $display("FAIL tol66_windows: got %0d expected 3", err_q.size()); else n_pass++;
        for (int i = 0; i < 3 && i < err_q.size(); i++) begin
            n_checks++; if (err_q[i] !== 17'(2)) $display("FAIL tol66_err[%0d]: got %0d expected 2", i, $signed(err_q[i])); else n_pass++;
            n_checks++; if (lock_q[i] !== exp_lock[i]) $display("FAIL tol66_lock[%0d]: got %b expected %b", i, lock_q[i], exp_lock[i]); else n_pass++;
        end
        apply_reset();
        repeat (4) run_window(67);
        ref_period(0, 1'b0);
        n_checks++; if (err_q.size() != 4) $display("FAIL tol67_windows: got %0d expected 4", err_q.size()); else n_pass++;
        for (int i = 0; i < 4 && i < err_q.size(); i++) begin
            n_checks++; if (err_q[i] !== 17'(3)) $display("FAIL tol67_err[%0d]: got %0d expected 3", i, $signed(err_q[i])); else n_pass++;
            n_checks++; if (lock_q[i] !== 1'b0) $display("FAIL tol67_lock[%0d]: got %b expected 0", i, lock_q[i]); else n_pass++;
        end
        n_checks++; if (lock_digital !== 1'b0) $display("FAIL tol67_final_lock: got %b expected 0", lock_digital); else n_pass++;
    endtask

    task automatic test_slip();
        int   cnt[6]      = '{64, 64, 64, 60, 64, 64};
        int   exp_err[6]  = '{0, 0, 0, -4, 0, 0};
        logic exp_lock[6] = '{0, 0, 1, 1, 1, 1};
        apply_reset();
        for (int w = 0; w < 6; w++) run_window(cnt[w]);
        ref_period(0, 1'b0);
        n_checks++; if (err_q.size() != 6) $display("FAIL slip_windows: got %0d expected 6", err_q.size()); else n_pass++;
        for (int i = 0; i < 6 && i < err_q.size(); i++) begin
            n_checks++; if (err_q[i] !== 17'(exp_err[i])) $display("FAIL slip_err[%0d]: got %0d expected %0d", i, $signed(err_q[i]), exp_err[i]); else n_pass++;
            n_checks++; if (lock_q[i] !== exp_lock[i]) $display("FAIL slip_lock[%0d]: got %b expected %b", i, lock_q[i], exp_lock[i]); else n_pass++;
        end
        n_checks++; if (lost_cnt != 0) $display("FAIL slip_lost: got %0d expected 0", lost_cnt); else n_pass++;
    endtask

    task automatic test_unlock();
        int   cnt[8]      = '{64, 64, 64, 50, 50, 64, 64, 64};
        int   exp_err[8]  = '{0, 0, 0, -14, -14, 0, 0, 0};
        logic exp_lock[8] = '{0, 0, 1, 1, 0, 0, 0, 1};
        logic exp_lost[8] = '{0, 0, 0, 0, 1, 0, 0, 0};
        apply_reset();
        for (int w = 0; w < 8; w++) run_window(cnt[w]);
        ref_period(0, 1'b0);
        n_checks++; if (err_q.size() != 8) $display("FAIL unlock_windows: got %0d expected 8", err_q.size()); else n_pass++;
        for (int i = 0; i < 8 && i < err_q.size(); i++) begin
            n_checks++; if (err_q[i] !== 17'(exp_err[i])) $display("FAIL unlock_err[%0d]: got %0d expected %0d", i, $signed(err_q[i]), exp_err[i]); else n_pass++;
            n_checks++; if (lock_q[i] !== exp_lock[i]) $display("FAIL unlock_lock[%0d]: got %b expected %b", i, lock_q[i], exp_lock[i]); else n_pass++;
            n_checks++; if (lost_q[i] !== exp_lost[i]) $display("FAIL unlock_lost[%0d]: got %b expected %b", i, lost_q[i], exp_lost[i]); else n_pass++;
        end
        n_checks++; if (lost_cnt != 1) $display("FAIL unlock_lost_cycles: got %0d expected 1", lost_cnt); else n_pass++;
    endtask

    task automatic test_no_output();
        apply_reset();
        repeat (3) run_window(0);
        ref_period(0, 1'b0);
        n_checks++; if (err_q.size() != 3) $display("FAIL noout_windows: got %0d expected 3", err_q.size()); else n_pass++;
        for (int i = 0; i < 3 && i < err_q.size(); i++) begin
            n_checks++; if (err_q[i] !== 17'(-64)) $display("FAIL noout_err[%0d]: got %0d expected -64", i, $signed(err_q[i])); else n_pass++;
            n_checks++; if (lock_q[i] !== 1'b0) $display("FAIL noout_lock[%0d]: got %b expected 0", i, lock_q[i]); else n_pass++;
        end
    endtask

    task automatic test_coincident();
        apply_reset();
        repeat (3) ref_period(16, 1'b0);
        ref_period(15, 1'b0);
        ref_period(16, 1'b1);
        repeat (3) ref_period(16, 1'b0);
        ref_period(0, 1'b0);
        n_checks++; if (err_q.size() != 2) $display("FAIL coinc_windows: got %0d expected 2", err_q.size()); else n_pass++;
        for (int i = 0; i < 2 && i < err_q.size(); i++) begin
            n_checks++; if (err_q[i] !== 17'(0)) $display("FAIL coinc_err[%0d]: got %0d expected 0", i, $signed(err_q[i])); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        repeat (3) run_window(64);
        ref_period(16, 1'b0);
        ref_period(8, 1'b0);
        n_checks++; if (lock_digital !== 1'b1) $display("FAIL midrst_prelock: got %b expected 1", lock_digital); else n_pass++;
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (lock_digital !== 1'b0) $display("FAIL midrst_async_lock: got %b expected 0", lock_digital); else n_pass++;
        n_checks++; if (freq_error_real !== '0) $display("FAIL midrst_async_err: got %0d expected 0", $signed(freq_error_real)); else n_pass++;
        n_checks++; if (window_done_digital !== 1'b0) $display("FAIL midrst_async_done: got %b expected 0", window_done_digital); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        err_q.delete(); lock_q.delete(); lost_q.delete(); cyc_q.delete();
        lost_cnt = 0;
        for (int c = 0; c < 200; c++) drive_cycle(1'b0, c[0], c);
        n_checks++; if (err_q.size() != 0) $display("FAIL midrst_stuck_ref: got %0d windows expected 0", err_q.size()); else n_pass++;
        run_window(64);
        n_checks++; if (err_q.size() != 0) $display("FAIL midrst_early_done: got %0d windows expected 0", err_q.size()); else n_pass++;
        ref_period(0, 1'b0);
        n_checks++; if (err_q.size() != 1) $display("FAIL midrst_first_done: got %0d windows expected 1", err_q.size()); else n_pass++;
        if (err_q.size() > 0) begin
            n_checks++; if (err_q[0] !== 17'(0)) $display("FAIL midrst_err: got %0d expected 0", $signed(err_q[0])); else n_pass++;
            n_checks++; if (cyc_q[0] != 0) $display("FAIL midrst_latency: got cycle %0d expected 0", cyc_q[0]); else n_pass++;
        end
        n_checks++; if (lost_cnt != 0) $display("FAIL midrst_lost: got %0d expected 0", lost_cnt); else n_pass++;
        n_checks++; if (lock_digital !== 1'b0) $display("FAIL midrst_lock: got %b expected 0", lock_digital); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_exact();
        test_tolerance();
        test_slip();
        test_unlock();
        test_no_output();
        test_coincident();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pll_lock_detector.md
Name: pll_lock_detector

Overview:
- Observer that monitors the PLL from the opposite side of its clock interface: it consumes the reference clock and the PLL output clock and reports frequency lock status.
- Counts output-clock rising edges over a fixed number of reference periods and compares the count against the divide ratio.
- Drives a debounced lock flag, a loss-of-lock pulse and a signed frequency error.
- Instantiated beside phase_locked_loop at testbench/top level; sampled on the event-driven simulator clock.

Parameters:
- DIV_RATIO, 16: feedback divide ratio (expected output edges per reference period).
- WINDOW_REF_CYCLES, 4: reference periods per measurement window.
- TOL, 2: allowed |count − expected| for a window to be good.
- LOCK_WINDOWS, 3: consecutive good windows required to assert lock.
- UNLOCK_WINDOWS, 2: consecutive bad windows required to drop lock.
- COUNT_W, 16: edge counter width.

Ports:
- clk  input  1  event-driven simulator clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- reference_clk_digital  input  1  PLL reference clock, sampled on clk.
- output_clk_digital  input  1  PLL output clock, sampled on clk.
- lock_digital  output  1  high while locked.
- lost_lock_digital  output  1  one-cycle pulse when lock drops.
- window_done_digital  output  1  one-cycle pulse when a window closes.
- freq_error_real  output  COUNT_W+1  signed (count − expected) of the last window.

Behaviour:
- Reset (reset low, asynchronous): all outputs 0; counters 0; previous-sample registers 0; state WAIT_FIRST.
- Edge detect: a rising edge is the current sample = 1 with the previous registered sample = 0. Both inputs are registered every clk.
- EXPECTED = DIV_RATIO*WINDOW_REF_CYCLES, computed at elaboration. The tolerance check uses COUNT_W+1 signed arithmetic.
- WAIT_FIRST: output edges are ignored. The first reference rising edge opens a window (edge counters cleared) and moves to ACQUIRING.
- Window:
  - Each output rising edge increments out_cnt; out_cnt saturates at 2^COUNT_W−1.
  - Each reference rising edge increments ref_cnt.
  - When ref_cnt reaches WINDOW_REF_CYCLES, the window closes on that clk cycle.
- Window close:
  - An output edge coincident with the closing reference edge is counted into the closing window.
  - freq_error_real is registered from out_cnt − EXPECTED; window_done_digital pulses the following cycle together with the updated freq_error_real. Latency is one clk from the closing reference edge.
  - A new window opens immediately with both counters reset to 0. The closing reference edge does not count toward the next window.
- Good window: |freq_error| <= TOL.
- FSM (evaluated at window close):
  - ACQUIRING:
    - Good window: good_cnt++.
    - Bad window: good_cnt = 0.
    - good_cnt reaching LOCK_WINDOWS: go to LOCKED, lock_digital = 1, good_cnt cleared.
  - LOCKED: bad window → SLIPPING with bad_cnt = 1; good window stays in LOCKED.
  - SLIPPING: lock_digital stays 1.
    - Good window: return to LOCKED, bad_cnt = 0.
    - Bad window: bad_cnt++. When bad_cnt reaches UNLOCK_WINDOWS, go to ACQUIRING, lock_digital = 0, lost_lock_digital pulses one cycle, and good_cnt and bad_cnt are cleared.
  - If UNLOCK_WINDOWS = 1, the first bad window in LOCKED goes directly to ACQUIRING.
- Stuck reference (no reference edges): the window never closes and the state holds. No timeout.
- Reset asserted mid-window: immediate return to WAIT_FIRST; the partial window is discarded and no pulses are emitted.
- Output clock absent: out_cnt = 0, freq_error = −EXPECTED, the window is bad.

Decomposition:
- Package pll_pkg: typedef enum lock_state_t {WAIT_FIRST, ACQUIRING, LOCKED, SLIPPING}, plus a shared edge-detect helper function. PLL-wide default constants (DIV_RATIO) go here so they are shared with frequency_divider.
- One sub-module is natural: pll_window_counter, containing the edge detectors, ref_cnt/out_cnt, saturation and the window-close strobe. The top holds the FSM and outputs.

Test Plan (defaults DIV_RATIO=16, WINDOW_REF_CYCLES=4, TOL=2, LOCK_WINDOWS=3, UNLOCK_WINDOWS=2; EXPECTED=64):
- Exact 16× output vs reference, 5 windows → freq_error_real=0 each window; lock_digital rises one clk after the 3rd window close.
- Output at 66 edges/window → good windows, lock after 3 windows. At 67 edges/window → freq_error=+3, lock never asserted.
- Locked, then 1 bad window (60 edges), then good → lock_digital stays 1, no lost_lock pulse.
- Locked, then 2 consecutive windows of 50 edges → freq_error=−14; lost_lock_digital pulses once; lock_digital=0; re-lock requires 3 fresh good windows.
- Output held 0 → freq_error=−64 per window, never locks. Output edge coincident with a closing reference edge → counted in the closing window (count 64, not 63).
- Reset pulsed low mid-window while locked → outputs 0 asynchronously; after release, no window_done pulse until the first reference edge plus 4 reference periods.
